// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the MEM-stage load/store port.
// One request per ready/valid handshake, optional wait states, byte-lane
// aligned stores and sign/zero-extended sub-word loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic [3:0]  req_web,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic            ready_q, valid_q, busy_q;
    logic            fault_q, load_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [31:0]     word_q;

    // Request fields latched at acceptance (used when wait states exist)
    logic [3:0]      lat_web_q;
    logic [AW+1:0]   lat_addr_q;
    logic [31:0]     lat_wdata_q;
    logic [2:0]      lat_f3_q;

    logic            present, accept, commit;
    logic [3:0]      sel_web;
    logic [AW+1:0]   sel_addr;
    logic [31:0]     sel_wdata;
    logic [2:0]      sel_f3;
    logic            acc_store, acc_fault, mask_legal, is_half, is_word;
    logic [1:0]      acc_off;
    logic [3:0]      acc_lanes;
    logic [31:0]     acc_wdata;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     shifted, fmt;

    logic [31:0] mem [DEPTH_WORDS];

    // Upper address bits only matter modulo the array size
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign present = req_read | (req_web != 4'hF);
    assign accept  = present & ready_q;

    // Zero-wait accesses use the live request on the accept edge itself;
    // otherwise the latched copy is used on the edge leaving WAIT.
    assign sel_web   = (WAIT_CYCLES == 0) ? req_web             : lat_web_q;
    assign sel_addr  = (WAIT_CYCLES == 0) ? req_addr[AW+1:0]    : lat_addr_q;
    assign sel_wdata = (WAIT_CYCLES == 0) ? req_wdata           : lat_wdata_q;
    assign sel_f3    = (WAIT_CYCLES == 0) ? req_funct3          : lat_f3_q;
    assign commit    = (WAIT_CYCLES == 0) ? accept
                                          : (state_q == S_WAIT && cnt_q == 3'd0);

    // Decode the access: store/load, lane alignment and fault conditions
    always_comb begin
        acc_store  = (sel_web != 4'hF);
        acc_off    = sel_addr[1:0];
        acc_idx    = sel_addr[AW+1:2];
        mask_legal = (sel_web == 4'hF) || (sel_web == 4'hE) ||
                     (sel_web == 4'hC) || (sel_web == 4'h0);
        is_half    = (sel_web == 4'hC) || (sel_f3[1:0] == 2'b01);
        is_word    = (sel_web == 4'h0) || (sel_f3 == 3'b010);
        acc_fault  = !mask_legal || (is_half && acc_off == 2'd3) ||
                     (is_word && acc_off != 2'd0);
        acc_lanes  = (~sel_web) << acc_off;
        acc_wdata  = sel_wdata << {acc_off, 3'b000};
    end

    // Word array: byte-lane write commit and registered read sample
    always_ff @(posedge clk) begin
        if (commit) begin
            if (acc_store && !acc_fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (acc_lanes[i]) begin
                        mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                    end
                end
            end
            word_q <= mem[acc_idx];
        end
    end

    // Control FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
            load_q      <= 1'b0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            lat_web_q   <= 4'hF;
            lat_addr_q  <= '0;
            lat_wdata_q <= 32'd0;
            lat_f3_q    <= 3'd0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        lat_web_q   <= req_web;
                        lat_addr_q  <= req_addr[AW+1:0];
                        lat_wdata_q <= req_wdata;
                        lat_f3_q    <= req_funct3;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= 3'(WAIT_CYCLES - 1);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_RESP;
                            valid_q <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_RESP;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
            if (commit) begin
                fault_q <= acc_fault;
                load_q  <= !acc_store;
                off_q   <= acc_off;
                f3_q    <= sel_f3;
            end
        end
    end

    // Load formatting from the sampled word; zero for stores and faults
    always_comb begin
        shifted = word_q >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  fmt = word_q;
            3'b100:  fmt = {24'd0, shifted[7:0]};
            3'b101:  fmt = {16'd0, shifted[15:0]};
            default: fmt = word_q;
        endcase
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign busy       = busy_q;
    assign resp_fault = fault_q;
    assign resp_rdata = (load_q && !fault_q) ? fmt : 32'd0;

endmodule
